// File: rtl/fft_serial_collector.sv
// Packs PACK serial complex beats (BE_PARALLELISM lanes of {imag, real}) into wide words behind a FWFT FIFO.
// Optional A/B valid mismatch detection is enabled with `define FFT_COLLECT_LANE_CHECK_EN.
module fft_serial_collector #(
  parameter int DATA_WIDTH      = 16,
  parameter int BE_PARALLELISM  = 32,
  parameter int OUTPUT_AXI_CHNL = 8,
  parameter int PACK            = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [15:0]                               length,
  input  logic [OUTPUT_AXI_CHNL-1:0]                up_serial_vld_A,
  input  logic [DATA_WIDTH*BE_PARALLELISM-1:0]      up_serial_dat_A,
  input  logic [OUTPUT_AXI_CHNL-1:0]                up_serial_vld_B,
  input  logic [DATA_WIDTH*BE_PARALLELISM-1:0]      up_serial_dat_B,
  output logic                                      up_serial_rdy,
  output logic                                      dn_vld,
  output logic [PACK*2*DATA_WIDTH*BE_PARALLELISM-1:0] dn_dat,
  input  logic                                      dn_rdy,
  output logic                                      frame_done,
  output logic                                      lane_err
);
  // Handshakes: upstream beat moves when vld_A[0] && vld_B[0] && up_serial_rdy at posedge;
  // downstream word moves when dn_vld && dn_rdy at posedge; dn_dat is stable while dn_vld waits.
  localparam int BEAT_W = 2 * DATA_WIDTH * BE_PARALLELISM;
  localparam int WORD_W = PACK * BEAT_W;
  localparam int PW     = $clog2(PACK);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                run_q;
  logic [15:0]         len_q;
  logic [15:0]         sample_cnt_q;
  logic [PW-1:0]       pack_idx_q;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   word_merged;
  logic [BEAT_W-1:0]   beat;
  logic [WORD_W-1:0]   push_data;
  logic                push, pop, full, accept, last_beat, word_full, fd_d;
  logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                unused_vld;

  assign unused_vld = ^{up_serial_vld_A[OUTPUT_AXI_CHNL-1:1], up_serial_vld_B[OUTPUT_AXI_CHNL-1:1]};

  always_comb begin
    beat = '0;
    for (int g = 0; g < BE_PARALLELISM; g++) begin
      beat[g*2*DATA_WIDTH +: DATA_WIDTH]            = up_serial_dat_A[g*DATA_WIDTH +: DATA_WIDTH];
      beat[g*2*DATA_WIDTH+DATA_WIDTH +: DATA_WIDTH] = up_serial_dat_B[g*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Slots are zeroed after every push, so a partial word flushes with zero padding.
  always_comb begin
    word_merged = word_q;
    for (int k = 0; k < PACK; k++) begin
      if (PW'(k) == pack_idx_q) word_merged[k*BEAT_W +: BEAT_W] = beat;
    end
  end

  assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
  assign dn_vld        = (count_q != '0);
  assign dn_dat        = dn_vld ? fifo_mem[rd_ptr_q] : '0;
  assign pop           = dn_vld && dn_rdy;
  assign up_serial_rdy = run_q && (state_q != FLUSH) && !full && ((state_q != IDLE) || (length != 16'd0));
  assign accept        = up_serial_rdy && up_serial_vld_A[0] && up_serial_vld_B[0];
  assign last_beat     = (state_q == IDLE) ? (length == 16'd1) : ((sample_cnt_q + 16'd1) == len_q);
  assign word_full     = (pack_idx_q == PW'(PACK - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last_beat ? FLUSH : COLLECT;
      COLLECT: if (accept && last_beat) state_d = FLUSH;
      FLUSH:   if ((pack_idx_q == '0) || !full || pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (FIFO push and frame_done request)
  always_comb begin
    push      = 1'b0;
    push_data = word_merged;
    fd_d      = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        push = accept && word_full;
        fd_d = accept && last_beat && word_full;
      end
      FLUSH: begin
        if ((pack_idx_q != '0) && (!full || pop)) begin
          push      = 1'b1;
          push_data = word_q;
          fd_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      len_q        <= '0;
      sample_cnt_q <= '0;
      pack_idx_q   <= '0;
      word_q       <= '0;
      frame_done   <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      frame_done <= fd_d;
      if (push)        word_q <= '0;
      else if (accept) word_q <= word_merged;
      if (accept) begin
        if (state_q == IDLE) len_q <= length;
        sample_cnt_q <= sample_cnt_q + 16'd1;
        pack_idx_q   <= pack_idx_q + PW'(1);
      end else if ((state_q == FLUSH) && (state_d == IDLE)) begin
        sample_cnt_q <= '0;
        pack_idx_q   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef FFT_COLLECT_LANE_CHECK_EN
  logic lane_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_err_q <= 1'b0;
    else if (up_serial_rdy && (up_serial_vld_A[0] != up_serial_vld_B[0])) lane_err_q <= 1'b1;
  end
  assign lane_err = lane_err_q;
`else
  assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_serial_collector.sv
// Randomized and directed bench for fft_serial_collector against a queue-based frame/FIFO model.
module tb_fft_serial_collector;
  localparam int DW = 16;
  localparam int BP = 32;
  localparam int CH = 8;
  localparam int PK = 4;
  localparam int FD = 4;
  localparam int BW = 2 * DW * BP;
  localparam int WW = PK * BW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic [15:0]      length = '0;
  logic [CH-1:0]    vld_a = '0, vld_b = '0;
  logic [DW*BP-1:0] dat_a = '0, dat_b = '0;
  logic             dn_rdy = 1'b0;
  logic             up_serial_rdy, dn_vld, frame_done, lane_err;
  logic [WW-1:0]    dn_dat;

  fft_serial_collector #(
    .DATA_WIDTH(DW), .BE_PARALLELISM(BP), .OUTPUT_AXI_CHNL(CH), .PACK(PK), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .length(length),
    .up_serial_vld_A(vld_a), .up_serial_dat_A(dat_a),
    .up_serial_vld_B(vld_b), .up_serial_dat_B(dat_b),
    .up_serial_rdy(up_serial_rdy), .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_rdy(dn_rdy),
    .frame_done(frame_done), .lane_err(lane_err)
  );

`ifdef FFT_COLLECT_LANE_CHECK_EN
  localparam bit LANE_CHECK = 1'b1;
`else
  localparam bit LANE_CHECK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: frame progress, beats of the word in progress, buffered words
  logic [BW-1:0] cur_q[$];
  logic [WW-1:0] exp_q[$];
  bit  m_run, m_in_frame, m_flushing, m_fd, m_err;
  int  m_remaining;
  bit  allow_mismatch = 1'b0;

  // observations
  logic [WW-1:0] pop_q[$];
  int fd_cnt  = 0;
  int acc_cnt = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0b want %0b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      int i = 0;
      bad++;
      while (i < WW / 32 && act[i*32 +: 32] === exp[i*32 +: 32]) i++;
      $display("FAIL %s at %0t: bits[%0d+:32] got %h want %h", name, $time, i * 32,
               act[i*32 +: 32], exp[i*32 +: 32]);
    end
  endtask

  function automatic logic [BW-1:0] make_beat(input logic [DW*BP-1:0] a, input logic [DW*BP-1:0] b);
    logic [BW-1:0] r;
    for (int g = 0; g < BP; g++) r[g*2*DW +: 2*DW] = {b[g*DW +: DW], a[g*DW +: DW]};
    return r;
  endfunction

  function automatic bit m_rdy();
    return m_run && !m_flushing && (exp_q.size() < FD) && (m_in_frame || length != 16'd0);
  endfunction

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    m_run = 0; m_in_frame = 0; m_flushing = 0; m_fd = 0; m_err = 0; m_remaining = 0;
  endtask

  task automatic model_push_word();
    logic [WW-1:0] w = '0;
    for (int k = 0; k < cur_q.size(); k++) w[k*BW +: BW] = cur_q[k];
    exp_q.push_back(w);
    cur_q.delete();
  endtask

  // advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    bit r   = m_rdy();
    bit pop = (exp_q.size() > 0) && dn_rdy;
    bit acc = r && vld_a[0] && vld_b[0];
    if (LANE_CHECK && r && (vld_a[0] != vld_b[0])) m_err = 1;
    m_fd = 0;
    if (pop) void'(exp_q.pop_front());
    if (m_flushing) begin
      if (cur_q.size() == 0) m_flushing = 0;
      else if (exp_q.size() < FD) begin
        model_push_word();
        m_fd = 1;
        m_flushing = 0;
      end
    end else if (acc) begin
      if (!m_in_frame) begin
        m_in_frame  = 1;
        m_remaining = int'(length);
      end
      cur_q.push_back(make_beat(dat_a, dat_b));
      m_remaining--;
      if (cur_q.size() == PK) model_push_word();
      if (m_remaining == 0) begin
        m_in_frame = 0;
        m_flushing = 1;
        if (cur_q.size() == 0) m_fd = 1;
      end
    end
    m_run = 1;
  endtask

  // compare every output against the model, then step one clock
  task automatic cycle();
    #1;
    check_bit("up_serial_rdy", up_serial_rdy, m_rdy());
    check_bit("dn_vld", dn_vld, exp_q.size() > 0);
    if (exp_q.size() > 0) check_word("dn_dat", dn_dat, exp_q[0]);
    check_bit("frame_done", frame_done, m_fd);
    check_bit("lane_err", lane_err, m_err);
    if (dn_vld && dn_rdy) pop_q.push_back(dn_dat);
    if (frame_done) fd_cnt++;
    if (up_serial_rdy && vld_a[0] && vld_b[0]) acc_cnt++;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_bit("rst_dn_vld", dn_vld, 1'b0);
    check_bit("rst_rdy", up_serial_rdy, 1'b0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    check_bit("rst_lane_err", lane_err, 1'b0);
    check_word("rst_dn_dat", dn_dat, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic drive_beat(input int s, input bit pattern);
    vld_a = CH'($urandom) | CH'(1);
    vld_b = CH'($urandom) | CH'(1);
    for (int g = 0; g < BP; g++) begin
      dat_a[g*DW +: DW] = pattern ? DW'(g) : DW'($urandom);
      dat_b[g*DW +: DW] = pattern ? DW'(s) : DW'($urandom);
    end
  endtask

  task automatic drive_gap();
    int sel = $urandom_range(0, 3);
    vld_a = CH'($urandom) & ~CH'(1);
    vld_b = CH'($urandom) & ~CH'(1);
    if (allow_mismatch && sel == 1) vld_a[0] = 1'b1;
    if (allow_mismatch && sel == 2) vld_b[0] = 1'b1;
    dat_a = {BP{DW'($urandom)}};
    dat_b = {BP{DW'($urandom)}};
  endtask

  task automatic run_frame(input int len, input bit pattern, input int rdy_pct, input int vld_pct,
                           input int stop_after);
    int s = 0;
    int guard = 0;
    length = 16'(len);
    while (s < len && s < stop_after && guard < 3000) begin
      bit acc;
      dn_rdy = ($urandom_range(1, 100) <= rdy_pct);
      if ($urandom_range(1, 100) <= vld_pct) drive_beat(s, pattern);
      else drive_gap();
      acc = m_rdy() && vld_a[0] && vld_b[0];
      cycle();
      if (acc) s++;
      guard++;
    end
    check_bit("frame_progress", guard < 3000, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    drive_gap();
    vld_a[0] = 1'b0;
    vld_b[0] = 1'b0;
    dn_rdy = 1'b1;
    while ((exp_q.size() > 0 || m_flushing || m_in_frame || m_fd) && guard < 100) begin
      cycle();
      guard++;
    end
    check_bit("drain_progress", guard < 100, 1'b1);
    cycle();
  endtask

  task automatic clear_obs();
    pop_q.delete();
    fd_cnt = 0;
    acc_cnt = 0;
  endtask

  // literal expectation for pattern frames: word w, beat k, lane g = {4w+k, g}
  task automatic check_pattern(input string name, input int nwords);
    check_int({name, "_words"}, pop_q.size(), nwords);
    for (int w = 0; w < nwords && w < pop_q.size(); w++) begin
      logic [WW-1:0] e;
      for (int k = 0; k < PK; k++)
        for (int g = 0; g < BP; g++) e[k*BW + g*2*DW +: 2*DW] = {16'(PK * w + k), 16'(g)};
      check_word(name, pop_q[w], e);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] e26;
    @(negedge clk);
    apply_reset();
    cycle();

    // 128-beat frame, continuous
    clear_obs();
    run_frame(128, 1'b1, 100, 100, 1 << 30);
    drain();
    check_pattern("len128", 32);
    check_int("len128_frame_done", fd_cnt, 1);

    // length 6: second word half filled, zero padded
    clear_obs();
    run_frame(6, 1'b1, 100, 100, 1 << 30);
    drain();
    check_int("len6_words", pop_q.size(), 2);
    check_int("len6_frame_done", fd_cnt, 1);
    e26 = '0;
    for (int g = 0; g < BP; g++) begin
      e26[g*2*DW +: 2*DW]      = {16'd4, 16'(g)};
      e26[BW + g*2*DW +: 2*DW] = {16'd5, 16'(g)};
    end
    if (pop_q.size() == 2) check_word("len6_word1", pop_q[1], e26);

    // back-pressure: 20 offered beats with dn_rdy low
    clear_obs();
    length = 16'd20;
    dn_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_beat(acc_cnt, 1'b1);
      cycle();
    end
    #1;
    check_int("stall_accepted", acc_cnt, 16);
    check_bit("stall_rdy_low", up_serial_rdy, 1'b0);
    run_frame(20 - acc_cnt, 1'b0, 100, 100, 1 << 30);
    drain();
    check_int("stall_words", pop_q.size(), 5);
    pop_q.delete();
    pop_q.push_back('0);

    // reset in the middle of a frame
    clear_obs();
    run_frame(128, 1'b1, 50, 100, 50);
    @(negedge clk);
    apply_reset();
    clear_obs();
    run_frame(128, 1'b1, 100, 100, 1 << 30);
    drain();
    check_pattern("after_reset", 32);
    check_int("after_reset_frame_done", fd_cnt, 1);

    // length 0 never accepts
    clear_obs();
    length = 16'd0;
    dn_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_beat(i, 1'b0);
      cycle();
    end
    check_int("len0_accepted", acc_cnt, 0);
    check_int("len0_words", pop_q.size(), 0);
    check_int("len0_frame_done", fd_cnt, 0);

    // A/B valid mismatch for one cycle
    clear_obs();
    length = 16'd8;
    drive_beat(0, 1'b0);
    vld_b[0] = 1'b0;
    cycle();
    check_int("mismatch_accepted", acc_cnt, 0);
    #1;
    check_bit("mismatch_lane_err", lane_err, LANE_CHECK);
    run_frame(8, 1'b0, 100, 100, 1 << 30);
    drain();
    check_int("mismatch_frame_words", pop_q.size(), 2);

    // randomized frames with bubbles, mismatches and back-pressure
    allow_mismatch = 1'b1;
    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(1, 21), 1'b0, $urandom_range(20, 100), $urandom_range(40, 100), 1 << 30);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    check_bit("lane_err_sticky", lane_err, LANE_CHECK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
